// File: rtl/bcd_sub.sv
// Registered 3-digit BCD subtractor: |A - B| with a sign flag, one cycle latency.
// Optional macro BCD_SUB_CHECK_EN adds the `invalid` output and flags out-of-range digits instead of saturating them.
module bcd_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a_ones,
  input  logic [3:0] a_tens,
  input  logic [3:0] a_huns,
  input  logic [3:0] b_ones,
  input  logic [3:0] b_tens,
  input  logic [3:0] b_huns,
  output logic [3:0] out_ones,
  output logic [3:0] out_tens,
  output logic [3:0] out_huns,
  output logic       negative,
  output logic       out_valid
`ifdef BCD_SUB_CHECK_EN
  ,
  output logic       invalid
`endif
);

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Returns {borrow_out, diff}; a negative raw difference is wrapped back into 0-9.
  function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic bin);
    logic [4:0] raw;
    logic [3:0] d;
    raw = {1'b0, x} - {1'b0, y} - {4'b0, bin};
    if (raw[4]) begin
      d = raw[3:0] + 4'd10;
      return {1'b1, d};
    end
    return {1'b0, raw[3:0]};
  endfunction

  logic [3:0] a0, a1, a2, b0, b1, b2;
  logic [4:0] ab0, ab1, ab2, ba0, ba1, ba2;
  logic       a_lt_b;
  logic [3:0] nxt_ones, nxt_tens, nxt_huns;
  logic       nxt_neg;
`ifdef BCD_SUB_CHECK_EN
  logic       digit_bad;
`endif

  // Both directions are computed in parallel; the final borrow of A-B picks the non-negative one.
  always_comb begin
    a0 = sat_digit(a_ones);
    a1 = sat_digit(a_tens);
    a2 = sat_digit(a_huns);
    b0 = sat_digit(b_ones);
    b1 = sat_digit(b_tens);
    b2 = sat_digit(b_huns);

    ab0 = sub_digit(a0, b0, 1'b0);
    ab1 = sub_digit(a1, b1, ab0[4]);
    ab2 = sub_digit(a2, b2, ab1[4]);
    ba0 = sub_digit(b0, a0, 1'b0);
    ba1 = sub_digit(b1, a1, ba0[4]);
    ba2 = sub_digit(b2, a2, ba1[4]);

    a_lt_b   = ab2[4];
    nxt_neg  = a_lt_b;
    nxt_ones = a_lt_b ? ba0[3:0] : ab0[3:0];
    nxt_tens = a_lt_b ? ba1[3:0] : ab1[3:0];
    nxt_huns = a_lt_b ? ba2[3:0] : ab2[3:0];

`ifdef BCD_SUB_CHECK_EN
    digit_bad = (a_ones > 4'd9) || (a_tens > 4'd9) || (a_huns > 4'd9) ||
                (b_ones > 4'd9) || (b_tens > 4'd9) || (b_huns > 4'd9);
    if (digit_bad) begin
      nxt_neg  = 1'b0;
      nxt_ones = 4'd0;
      nxt_tens = 4'd0;
      nxt_huns = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ones  <= 4'd0;
      out_tens  <= 4'd0;
      out_huns  <= 4'd0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      invalid   <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_ones <= nxt_ones;
        out_tens <= nxt_tens;
        out_huns <= nxt_huns;
        negative <= nxt_neg;
`ifdef BCD_SUB_CHECK_EN
        invalid  <= digit_bad;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_sub.sv
// Self-checking bench for bcd_sub: directed vectors plus a back-to-back random sweep against an integer model.
module tb_bcd_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a_ones, a_tens, a_huns, b_ones, b_tens, b_huns;
  logic [3:0] out_ones, out_tens, out_huns;
  logic       negative, out_valid;
`ifdef BCD_SUB_CHECK_EN
  logic       invalid;
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  bcd_sub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_ones(a_ones), .a_tens(a_tens), .a_huns(a_huns),
    .b_ones(b_ones), .b_tens(b_tens), .b_huns(b_huns),
    .out_ones(out_ones), .out_tens(out_tens), .out_huns(out_huns),
    .negative(negative), .out_valid(out_valid)
`ifdef BCD_SUB_CHECK_EN
    , .invalid(invalid)
`endif
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input logic v);
    a_huns = a[11:8]; a_tens = a[7:4]; a_ones = a[3:0];
    b_huns = b[11:8]; b_tens = b[7:4]; b_ones = b[3:0];
    in_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_bcd is the expected result written as three BCD digits.
  task automatic checkResult(input string tag, input logic exp_neg, input logic [11:0] exp_bcd,
                             input logic exp_valid, input logic exp_inv);
    checkOutput({tag, "_val"}, {3'b0, negative, out_huns, out_tens, out_ones},
                {3'b0, exp_neg, exp_bcd});
    checkOutput({tag, "_ov"}, {15'b0, out_valid}, {15'b0, exp_valid});
`ifdef BCD_SUB_CHECK_EN
    checkOutput({tag, "_inv"}, {15'b0, invalid}, {15'b0, exp_inv});
`else
    if (exp_inv) $display("[TB] note: %s expects invalid but port absent", tag);
`endif
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  initial begin
    int av, bv, diff;
    logic [11:0] abcd, bbcd;

    rst = 1'b1;
    applyStimulus(12'h000, 12'h000, 1'b0);
    tick(); tick();
    checkResult("reset", 1'b0, 12'h000, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(12'h123, 12'h045, 1'b1); tick();
    checkResult("123m045", 1'b0, 12'h078, 1'b1, 1'b0);
    applyStimulus(12'h999, 12'h111, 1'b0); tick();
    checkResult("hold", 1'b0, 12'h078, 1'b0, 1'b0);

    applyStimulus(12'h045, 12'h123, 1'b1); tick();
    checkResult("045m123", 1'b1, 12'h078, 1'b1, 1'b0);
    applyStimulus(12'h500, 12'h500, 1'b1); tick();
    checkResult("500m500", 1'b0, 12'h000, 1'b1, 1'b0);
    applyStimulus(12'h000, 12'h999, 1'b1); tick();
    checkResult("000m999", 1'b1, 12'h999, 1'b1, 1'b0);
    applyStimulus(12'h999, 12'h000, 1'b1); tick();
    checkResult("999m000", 1'b0, 12'h999, 1'b1, 1'b0);
    applyStimulus(12'h100, 12'h001, 1'b1); tick();
    checkResult("100m001", 1'b0, 12'h099, 1'b1, 1'b0);
    applyStimulus(12'h001, 12'h100, 1'b1); tick();
    checkResult("001m100", 1'b1, 12'h099, 1'b1, 1'b0);
    applyStimulus(12'h010, 12'h009, 1'b1); tick();
    checkResult("010m009", 1'b0, 12'h001, 1'b1, 1'b0);

    // Reset wins over a simultaneous accept.
    rst = 1'b1;
    applyStimulus(12'h900, 12'h001, 1'b1); tick();
    checkResult("rst_pri", 1'b0, 12'h000, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(12'h123, 12'h045, 1'b1); tick();
    checkResult("pre_rst", 1'b0, 12'h078, 1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b0; tick();
    checkResult("rst_after", 1'b0, 12'h000, 1'b0, 1'b0);
    rst = 1'b0;

    // Out-of-range digits: saturated to 9, or flagged when checking is enabled.
    applyStimulus(12'h1F1, 12'h000, 1'b1); tick();
    if (CHECK_EN) checkResult("bad_1F1", 1'b0, 12'h000, 1'b1, 1'b1);
    else          checkResult("sat_1F1", 1'b0, 12'h191, 1'b1, 1'b0);
    applyStimulus(12'h0A0, 12'h000, 1'b1); tick();
    if (CHECK_EN) checkResult("bad_0A0", 1'b0, 12'h000, 1'b1, 1'b1);
    else          checkResult("sat_0A0", 1'b0, 12'h090, 1'b1, 1'b0);
    applyStimulus(12'h010, 12'h00C, 1'b1); tick();
    if (CHECK_EN) checkResult("bad_00C", 1'b0, 12'h000, 1'b1, 1'b1);
    else          checkResult("sat_00C", 1'b0, 12'h001, 1'b1, 1'b0);
    applyStimulus(12'h321, 12'h123, 1'b1); tick();
    checkResult("321m123", 1'b0, 12'h198, 1'b1, 1'b0);

    // Back-to-back accepts with in_valid held high.
    for (int i = 0; i < 2000; i++) begin
      av = int'($urandom_range(0, 999));
      bv = int'($urandom_range(0, 999));
      if (i % 7 == 0) bv = av;
      abcd = to_bcd(av);
      bbcd = to_bcd(bv);
      applyStimulus(abcd, bbcd, 1'b1);
      tick();
      diff = (av >= bv) ? av - bv : bv - av;
      checkResult($sformatf("sweep%0d", i), (av < bv), to_bcd(diff), 1'b1, 1'b0);
    end

    in_valid = 1'b0; tick();
    checkOutput("idle_ov", {15'b0, out_valid}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/bcd_sub.md
# bcd_sub

Registered three-digit BCD subtractor: computes |A − B| for two unsigned 3-digit BCD operands (000–999), with a separate sign flag. Sits in the datapath between the keypad/digit-entry logic and the seven-segment display drivers. Produces one result per accepted operand pair, one clock after acceptance.

## Interface
- No parameters; width fixed at 3 BCD digits (4 bits each).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented this cycle are accepted.
- a_ones, a_tens, a_huns  input  4 each  minuend A digits, legal range 0–9.
- b_ones, b_tens, b_huns  input  4 each  subtrahend B digits, legal range 0–9.
- out_ones, out_tens, out_huns  output  4 each  BCD digits of |A − B|.
- negative  output  1  1 when A < B; 0 otherwise, including A = B.
- out_valid  output  1  one-cycle pulse: outputs updated from an accepted pair.
- invalid  output  1  present only with BCD_SUB_CHECK_EN; see Configuration.

## Operation
- A = 100·a_huns + 10·a_tens + a_ones; B likewise.
- If A ≥ B: result = A − B, negative = 0. Else: result = B − A, negative = 1.
- Result always in 0–999; each output digit always 0–9. Never negative zero.
- Implementation free: digit-wise subtract with borrow and decimal correction, a comparison, then operand swap or ten's-complement correction. Result must be numerically exact for all 10^6 legal input combinations.
- Without BCD_SUB_CHECK_EN, an input digit above 9 is saturated to 9 before computation. Example: a_ones = 4'hC is treated as 9.
- With in_valid = 0, the output registers hold their values and out_valid = 0.

## Timing
- Latency 1 cycle. Operands sampled on the edge where in_valid = 1. out_* digits, negative (and invalid) are valid after that edge, with out_valid = 1 for exactly that cycle.
- Back-to-back in_valid accepted every cycle. Throughput 1 result per clock. No backpressure.
- Outputs are registered. No combinational path from input to output.
- Reset values: out_ones = out_tens = out_huns = 0, negative = 0, out_valid = 0, invalid = 0.
- rst has priority over in_valid in the same cycle. That pair is discarded and all outputs take their reset values.
- Reset asserted the cycle after acceptance: the pending out_valid pulse is cleared on the reset edge.

## Configuration
- BCD_SUB_CHECK_EN defined:
  - Adds the `invalid` output port, registered with the result.
  - If any of the six input digits exceeds 9 on an accepted cycle: invalid = 1, result = 000, negative = 0, out_valid still pulses.
  - Otherwise invalid = 0.
- BCD_SUB_CHECK_EN undefined:
  - No `invalid` port.
  - Out-of-range digits are saturated to 9 as described in Operation.

## Test plan
- Reset, then A = 123, B = 045, in_valid for 1 cycle -> next cycle out = 0,7,8 (huns, tens, ones), negative = 0, out_valid = 1; the cycle after, out_valid = 0 and digits hold.
- A = 045, B = 123 -> out = 078, negative = 1. A = 500, B = 500 -> out = 000, negative = 0.
- Extremes with borrow chains: 000 − 999 -> 999, negative = 1; 999 − 000 -> 999, negative = 0; 100 − 001 -> 099, negative = 0.
- Exhaustive loop over all 10^6 legal digit combinations with in_valid held high -> every result matches the integer reference, one cycle late, with the correct sign.
- rst and in_valid both high with A = 900, B = 001 -> next cycle all outputs 0 and out_valid = 0.
- With BCD_SUB_CHECK_EN: a_tens = 4'hA, B = 000 -> invalid = 1, out = 000, negative = 0, out_valid = 1. Without it: A = 1,F,1 (digits) and B = 000 -> out = 191.
